// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one-at-a-time fetches to a
// variable-latency instruction memory and queues {PC, instruction} for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    input  logic        Stall,
    output logic        ImReq,
    output logic [63:0] ImAddr,
    input  logic        ImAck,
    input  logic [31:0] ImData,
    output logic        InstValid,
    output logic [31:0] Instruction,
    output logic [63:0] InstPC
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q;
    logic          req_q;
    logic [63:0]   addr_q, fetch_pc_q;

    logic [63:0] redir_pc;
    logic        deq, enq;

    assign redir_pc    = RedirectPC & ~64'h3;
    assign InstValid   = (cnt_q != '0);
    assign Instruction = mem_q[rd_q].instr;
    assign InstPC      = mem_q[rd_q].pc;
    assign ImReq       = req_q;
    assign ImAddr      = addr_q;

    // In WAIT and DROP a request is always live, so ImAck is only honoured there.
    assign deq   = InstValid && !Stall && !Redirect;
    assign enq   = (state_q == WAIT) && ImAck && !Redirect;
    assign cnt_d = cnt_q + CW'(enq) - CW'(deq);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (Redirect) begin
                cnt_q <= '0;
                rd_q  <= '0;
                wr_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (deq) rd_q <= rd_q + PW'(1);
                if (enq) begin
                    mem_q[wr_q] <= entry_t'{pc: addr_q, instr: ImData};
                    wr_q        <= wr_q + PW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (Redirect) begin
                        fetch_pc_q <= redir_pc;
                        req_q      <= 1'b1;
                        addr_q     <= redir_pc;
                        state_q    <= WAIT;
                    end else if (cnt_q < FULL) begin
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (ImAck) begin
                        if (Redirect) begin
                            addr_q     <= redir_pc;
                            fetch_pc_q <= redir_pc;
                        end else begin
                            fetch_pc_q <= addr_q + 64'd4;
                            // Keep streaming only while the post-edge queue still has room.
                            if (cnt_d < FULL) begin
                                addr_q <= addr_q + 64'd4;
                            end else begin
                                req_q   <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end else if (Redirect) begin
                        fetch_pc_q <= redir_pc;
                        state_q    <= DROP;
                    end
                end
                DROP: begin
                    if (Redirect) fetch_pc_q <= redir_pc;
                    if (ImAck) begin
                        addr_q  <= Redirect ? redir_pc : fetch_pc_q;
                        state_q <= WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
